// File: rtl/plugboard_pair_table_if.sv
// Config and translate signals of the plugboard pair table, bundled for port hookup.
// master = keyboard/controller side, slave = plugboard table.
interface plugboard_pair_table_if #(
  parameter int LETTERS = 26,
  parameter int IDXW    = 5
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [1:0]         cfg_cmd;
  logic [IDXW-1:0]    cfg_a;
  logic [IDXW-1:0]    cfg_b;
  logic               cfg_done;
  logic [2:0]         cfg_err;
  logic [IDXW-1:0]    pair_count;
  logic               in_valid;
  logic [LETTERS-1:0] in_letter;
  logic               out_valid;
  logic [LETTERS-1:0] out_letter;
  logic               out_bad;

  modport master (
    output cfg_valid, cfg_cmd, cfg_a, cfg_b, in_valid, in_letter,
    input  cfg_ready, cfg_done, cfg_err, pair_count, out_valid, out_letter, out_bad
  );

  modport slave (
    input  cfg_valid, cfg_cmd, cfg_a, cfg_b, in_valid, in_letter,
    output cfg_ready, cfg_done, cfg_err, pair_count, out_valid, out_letter, out_bad
  );
endinterface

// File: rtl/plugboard_pair_table.sv
// Programmable Enigma plugboard: letter-swap map with 1-cycle registered translation
// and a valid/ready config port for add/delete/clear of pairs.
//
// state    | meaning
// ---------+----------------------------------------------------------
// s_idle   | config port ready, waiting for a request
// s_check  | compute result code from latched operands and current map
// s_clear  | restore one map entry to identity per cycle, 0..LETTERS-1
// s_commit | apply the pending write if code is 0, pulse done
module plugboard_pair_table #(
  parameter int LETTERS   = 26,
  parameter int MAX_PAIRS = 10,
  parameter int IDXW      = 5
) (
  input logic                   clock,
  input logic                   resetn,
  plugboard_pair_table_if.slave bus
);

  localparam logic [1:0] CMD_ADD   = 2'd1;
  localparam logic [1:0] CMD_DEL   = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;

  typedef enum logic [1:0] {s_idle, s_check, s_clear, s_commit} state_t;

  state_t             state_q, state_d;
  logic [IDXW-1:0]    map_q [LETTERS];
  logic [1:0]         cmd_q;
  logic [IDXW-1:0]    a_q, b_q, count_q, clr_left_q, clr_idx;
  logic [2:0]         code_q, code_d, err_q;
  logic               done_q, accept;
  logic [IDXW-1:0]    map_a, map_b, in_idx, in_map;
  logic               in_ok;
  logic [LETTERS-1:0] in_xlat;
  logic               out_valid_q, out_bad_q;
  logic [LETTERS-1:0] out_letter_q;

  assign accept  = bus.cfg_valid && (state_q == s_idle);
  assign clr_idx = IDXW'(LETTERS - 1) - clr_left_q;

  // Loop-based lookups keep out-of-range operands from indexing past the map.
  always_comb begin
    map_a   = a_q;
    map_b   = b_q;
    in_idx  = '0;
    in_map  = '0;
    in_xlat = '0;
    in_ok   = $onehot(bus.in_letter);
    for (int k = 0; k < LETTERS; k++) begin
      if (IDXW'(k) == a_q) map_a = map_q[k];
      if (IDXW'(k) == b_q) map_b = map_q[k];
      if (bus.in_letter[k]) in_idx = IDXW'(k);
    end
    for (int k = 0; k < LETTERS; k++) begin
      if (IDXW'(k) == in_idx) in_map = map_q[k];
    end
    for (int k = 0; k < LETTERS; k++) begin
      in_xlat[k] = (in_map == IDXW'(k));
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= s_idle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    code_d  = 3'd0;
    case (state_q)
      s_idle: begin
        if (accept) state_d = (bus.cfg_cmd == CMD_CLEAR) ? s_clear : s_check;
      end
      s_check: begin
        state_d = s_commit;
        if (cmd_q == CMD_ADD) begin
          if (int'(a_q) >= LETTERS || int'(b_q) >= LETTERS) code_d = 3'd1;
          else if (a_q == b_q)                             code_d = 3'd2;
          else if (map_a != a_q || map_b != b_q)           code_d = 3'd3;
          else if (int'(count_q) == MAX_PAIRS)             code_d = 3'd4;
        end else if (cmd_q == CMD_DEL) begin
          if (int'(a_q) >= LETTERS) code_d = 3'd1;
          else if (map_a == a_q)    code_d = 3'd5;
        end
      end
      s_clear: begin
        if (clr_left_q == '0) state_d = s_commit;
      end
      s_commit: state_d = s_idle;
      default:  state_d = s_idle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cmd_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      count_q    <= '0;
      clr_left_q <= '0;
      code_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= '0;
      for (int k = 0; k < LETTERS; k++) map_q[k] <= IDXW'(k);
    end else begin
      done_q <= (state_q == s_commit);
      err_q  <= (state_q == s_commit) ? code_q : 3'd0;
      if (accept) begin
        cmd_q      <= bus.cfg_cmd;
        a_q        <= bus.cfg_a;
        b_q        <= bus.cfg_b;
        code_q     <= 3'd0;
        clr_left_q <= IDXW'(LETTERS - 1);
      end
      if (state_q == s_check) code_q <= code_d;
      if (state_q == s_clear) begin
        count_q <= '0;
        if (clr_left_q != '0) clr_left_q <= clr_left_q - IDXW'(1);
        for (int k = 0; k < LETTERS; k++) begin
          if (IDXW'(k) == clr_idx) map_q[k] <= IDXW'(k);
        end
      end
      // Both halves of a pair change on the same edge.
      if (state_q == s_commit && code_q == 3'd0) begin
        if (cmd_q == CMD_ADD) begin
          count_q <= count_q + IDXW'(1);
          for (int k = 0; k < LETTERS; k++) begin
            if (IDXW'(k) == a_q) map_q[k] <= b_q;
            if (IDXW'(k) == b_q) map_q[k] <= a_q;
          end
        end else if (cmd_q == CMD_DEL) begin
          count_q <= count_q - IDXW'(1);
          for (int k = 0; k < LETTERS; k++) begin
            if (IDXW'(k) == a_q || IDXW'(k) == map_a) map_q[k] <= IDXW'(k);
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      out_bad_q    <= 1'b0;
      out_letter_q <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      out_bad_q   <= bus.in_valid && !in_ok;
      if (bus.in_valid) out_letter_q <= in_ok ? in_xlat : '0;
    end
  end

  assign bus.cfg_ready  = (state_q == s_idle);
  assign bus.cfg_done   = done_q;
  assign bus.cfg_err    = err_q;
  assign bus.pair_count = count_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_bad    = out_bad_q;
  assign bus.out_letter = out_letter_q;

endmodule

// File: tb/tb_plugboard_pair_table.sv
// Self-checking bench for plugboard_pair_table: directed steps then random config and
// translate traffic, all checked against an array-based swap model.
module tb_plugboard_pair_table;
  localparam int L  = 26;
  localparam int MP = 10;
  localparam int W  = 5;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  plugboard_pair_table_if #(.LETTERS(L), .IDXW(W)) bus ();

  plugboard_pair_table #(.LETTERS(L), .MAX_PAIRS(MP), .IDXW(W)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  int ref_map [L];
  int ref_count;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_checks = 0;
  logic [L-1:0] last_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [L-1:0] oh(input int i);
    logic [L-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < L; i++) ref_map[i] = i;
    ref_count = 0;
  endtask

  function automatic int model_err(input int cmd, input int a, input int b);
    if (cmd == 1) begin
      if (a >= L || b >= L)                    return 1;
      if (a == b)                              return 2;
      if (ref_map[a] != a || ref_map[b] != b)  return 3;
      if (ref_count == MP)                     return 4;
    end else if (cmd == 2) begin
      if (a >= L)          return 1;
      if (ref_map[a] == a) return 5;
    end
    return 0;
  endfunction

  task automatic cfg(input int cmd, input int a, input int b);
    int e, lat, cyc, rl, p;
    e   = model_err(cmd, a, b);
    lat = (cmd == 3) ? L + 1 : 2;
    @(negedge clock);
    chk("cfg_ready_idle", bus.cfg_ready, 1);
    bus.cfg_valid = 1'b1;
    bus.cfg_cmd   = cmd[1:0];
    bus.cfg_a     = a[W-1:0];
    bus.cfg_b     = b[W-1:0];
    @(posedge clock); #1;
    bus.cfg_valid = 1'b0;
    cyc = 0;
    rl  = (bus.cfg_ready === 1'b0) ? 1 : 0;
    while (bus.cfg_done !== 1'b1 && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
      if (bus.cfg_ready === 1'b0) rl++;
    end
    chk("cfg_latency", cyc, lat);
    chk("cfg_ready_low", rl, lat);
    chk("cfg_err", bus.cfg_err, e);
    if (e == 0) begin
      if (cmd == 1) begin
        ref_map[a] = b;
        ref_map[b] = a;
        ref_count++;
      end else if (cmd == 2) begin
        p = ref_map[a];
        ref_map[a] = a;
        ref_map[p] = p;
        ref_count--;
      end else if (cmd == 3) begin
        model_reset();
      end
    end
    chk("pair_count", bus.pair_count, ref_count);
    @(posedge clock); #1;
    chk("cfg_done_pulse", bus.cfg_done, 0);
  endtask

  task automatic xlate(input logic [L-1:0] v);
    logic [L-1:0] exp;
    int idx;
    exp = '0;
    idx = 0;
    if ($countones(v) == 1) begin
      for (int i = 0; i < L; i++) if (v[i]) idx = i;
      exp[ref_map[idx]] = 1'b1;
    end
    @(negedge clock);
    bus.in_valid  = 1'b1;
    bus.in_letter = v;
    @(posedge clock); #1;
    chk("out_valid", bus.out_valid, 1);
    chk("out_letter", bus.out_letter, exp);
    chk("out_bad", bus.out_bad, ($countones(v) == 1) ? 0 : 1);
    last_exp = exp;
  endtask

  task automatic sweep();
    for (int i = 0; i < L; i++) xlate(oh(i));
  endtask

  initial begin
    logic [31:0] r32;
    logic [L-1:0] v;
    int r, cmd, a, b;

    bus.cfg_valid = 1'b0;
    bus.cfg_cmd   = '0;
    bus.cfg_a     = '0;
    bus.cfg_b     = '0;
    bus.in_valid  = 1'b0;
    bus.in_letter = '0;
    model_reset();

    #12;
    chk("rst_ready", bus.cfg_ready, 1);
    chk("rst_done", bus.cfg_done, 0);
    chk("rst_err", bus.cfg_err, 0);
    chk("rst_count", bus.pair_count, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_letter", bus.out_letter, 0);
    chk("rst_out_bad", bus.out_bad, 0);
    @(negedge clock);
    resetn = 1'b1;

    xlate(oh(4));
    chk("count_after_reset", bus.pair_count, 0);

    cfg(1, 0, 25);
    xlate(oh(0));
    xlate(oh(25));
    cfg(1, 0, 3);
    cfg(1, 7, 7);
    cfg(1, 26, 1);
    cfg(2, 5, 0);
    cfg(0, 0, 0);
    sweep();

    // Idle input: valid and bad drop, letter holds.
    @(negedge clock);
    bus.in_valid  = 1'b0;
    bus.in_letter = oh(9);
    @(posedge clock); #1;
    chk("idle_valid", bus.out_valid, 0);
    chk("idle_bad", bus.out_bad, 0);
    chk("idle_hold", bus.out_letter, last_exp);

    cfg(3, 0, 0);
    for (int i = 0; i < 10; i++) cfg(1, 2 * i, 2 * i + 1);
    cfg(1, 20, 21);
    sweep();
    cfg(2, 0, 0);
    xlate(oh(0));
    xlate(oh(1));
    cfg(1, 0, 1);
    cfg(3, 0, 0);
    sweep();

    repeat (60) begin
      r   = $urandom_range(0, 15);
      cmd = (r < 1) ? 3 : (r < 9) ? 1 : (r < 13) ? 2 : 0;
      a   = $urandom_range(0, 27);
      b   = $urandom_range(0, 27);
      cfg(cmd, a, b);
      v = oh($urandom_range(0, L - 1));
      if ($urandom_range(0, 3) == 0) begin
        r32 = $urandom;
        v   = r32[L-1:0];
      end
      xlate(v);
      xlate(oh($urandom_range(0, L - 1)));
    end

    // Reset in the middle of a CLEAR.
    cfg(3, 0, 0);
    cfg(1, 8, 9);
    cfg(1, 2, 14);
    xlate(oh(8));
    @(negedge clock);
    bus.cfg_valid = 1'b1;
    bus.cfg_cmd   = 2'd3;
    @(posedge clock); #1;
    bus.cfg_valid = 1'b0;
    repeat (10) @(posedge clock);
    #3 resetn = 1'b0;
    #1;
    model_reset();
    chk("midrst_ready", bus.cfg_ready, 1);
    chk("midrst_done", bus.cfg_done, 0);
    chk("midrst_count", bus.pair_count, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_letter", bus.out_letter, 0);
    chk("midrst_out_bad", bus.out_bad, 0);
    @(negedge clock);
    resetn = 1'b1;
    v = '0;
    v[1:0] = 2'b11;
    xlate(v);
    xlate('0);
    sweep();
    cfg(1, 3, 4);
    xlate(oh(3));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
